// File: rtl/conv_sched.sv
// conv_sched: layer scheduler for the 5x5 convolution engine.
// Starts the engine, addresses result beats linearly and guards with a watchdog.
module conv_sched #(
    parameter int N_KERNEL    = 30,
    parameter int OUT_DIM     = 24,
    parameter int D_WIDTH     = 32,
    parameter int A_WIDTH     = 15,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               img_vld,
    output logic               img_rdy,
    output logic               cal_start,
    input  logic [D_WIDTH-1:0] conv_rslt_act,
    input  logic               conv_rslt_act_vld,
    output logic               wr_en,
    output logic [A_WIDTH-1:0] wr_addr,
    output logic [D_WIDTH-1:0] wr_data,
    output logic [4:0]         kernel_idx,
    output logic               busy,
    output logic               layer_done,
    output logic               err,
    input  logic               err_clr
);

    localparam int CW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam int GW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OUT_DIM - 1);
    localparam logic [4:0]    K_LAST = 5'(N_KERNEL - 1);
    localparam logic [GW-1:0] G_LAST = GW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [CW-1:0]      r_col;
    logic [CW-1:0]      r_row;
    logic [4:0]         r_kernel;
    logic [A_WIDTH-1:0] r_addr;
    logic [GW-1:0]      r_gap;

    logic w_beat;
    logic w_last;
    logic w_timeout;
    logic w_accept;

    assign w_beat    = (r_state == S_RUN) && conv_rslt_act_vld;
    assign w_last    = w_beat && (r_kernel == K_LAST) &&
                       (r_row == C_LAST) && (r_col == C_LAST);
    assign w_timeout = (r_state == S_RUN) && !conv_rslt_act_vld &&
                       (r_gap == G_LAST);
    assign w_accept  = (r_state == S_IDLE) && img_vld && img_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_state_nx = S_START;
            S_START: w_state_nx = S_RUN;
            S_RUN: begin
                if (w_last) begin
                    w_state_nx = S_DONE;
                end else if (w_timeout) begin
                    w_state_nx = S_ERR;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            S_ERR:   if (err_clr) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Position counters track the next beat; a beat wins over the watchdog.
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_col    <= '0;
            r_row    <= '0;
            r_kernel <= '0;
            r_addr   <= '0;
            r_gap    <= '0;
        end else if (w_beat) begin
            r_gap  <= '0;
            r_addr <= r_addr + A_WIDTH'(1);
            if (r_col == C_LAST) begin
                r_col <= '0;
                if (r_row == C_LAST) begin
                    r_row    <= '0;
                    r_kernel <= r_kernel + 5'd1;
                end else begin
                    r_row <= r_row + CW'(1);
                end
            end else begin
                r_col <= r_col + CW'(1);
            end
        end else if (r_state == S_RUN) begin
            r_gap <= r_gap + GW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            img_rdy    <= 1'b0;
            cal_start  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            kernel_idx <= '0;
            busy       <= 1'b0;
            layer_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            img_rdy    <= (w_state_nx == S_IDLE);
            busy       <= (w_state_nx != S_IDLE);
            cal_start  <= (w_state_nx == S_START);
            layer_done <= (w_state_nx == S_DONE);
            err        <= (w_state_nx == S_ERR);
            wr_en      <= w_beat;
            if (w_accept) begin
                kernel_idx <= '0;
            end else if (w_beat) begin
                wr_addr    <= r_addr;
                wr_data    <= conv_rslt_act;
                kernel_idx <= r_kernel;
            end
        end
    end

endmodule
